// File: rtl/psram_rec_play_ctrl_pkg.sv
// Shared types and AXI constants for the PSRAM record/playback sequencer.
package psram_rec_play_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REC_WAIT  = 3'd1,
        S_REC_AW    = 3'd2,
        S_REC_W     = 3'd3,
        S_REC_B     = 3'd4,
        S_PLAY_AR   = 3'd5,
        S_PLAY_R    = 3'd6,
        S_PLAY_HOLD = 3'd7
    } ctrl_state_e;

    localparam logic [7:0]  AXI_LEN       = 8'd0;
    localparam logic [2:0]  AXI_SIZE      = 3'b010;
    localparam logic [1:0]  AXI_BURST     = 2'b01;
    localparam logic [2:0]  AXI_PROT      = 3'b001;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [23:0] BASE_ADDR_DEF = 24'h4;
    localparam int          SAMPLE_W      = 16;

    function automatic logic is_rec(input ctrl_state_e s);
        return (s == S_REC_WAIT) || (s == S_REC_AW) || (s == S_REC_W) || (s == S_REC_B);
    endfunction

    function automatic logic is_play(input ctrl_state_e s);
        return (s == S_PLAY_AR) || (s == S_PLAY_R) || (s == S_PLAY_HOLD);
    endfunction

endpackage

// File: rtl/psram_rec_play_ctrl_if.sv
// AXI4 master-side bundle between the sequencer and the PSRAM slave.
interface psram_rec_play_ctrl_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_awaddr;
    logic                m_awvalid, m_awready;
    logic [7:0]          m_awlen;
    logic [2:0]          m_awsize, m_awprot;
    logic [1:0]          m_awburst;
    logic [3:0]          m_awid, m_awcache, m_awqos, m_awregion;
    logic                m_awlock;

    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wlast, m_wvalid, m_wready;

    logic [1:0]          m_bresp;
    logic                m_bvalid, m_bready;

    logic [ADDR_W-1:0]   m_araddr;
    logic                m_arvalid, m_arready;
    logic [7:0]          m_arlen;
    logic [2:0]          m_arsize, m_arprot;
    logic [1:0]          m_arburst;
    logic [3:0]          m_arid, m_arcache, m_arqos, m_arregion;
    logic                m_arlock;

    logic [DATA_W-1:0]   m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rvalid, m_rready;

    modport master (
        output m_awaddr, m_awvalid, m_awlen, m_awsize, m_awprot, m_awburst,
               m_awid, m_awcache, m_awqos, m_awregion, m_awlock,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready,
        output m_araddr, m_arvalid, m_arlen, m_arsize, m_arprot, m_arburst,
               m_arid, m_arcache, m_arqos, m_arregion, m_arlock,
        input  m_arready,
        input  m_rdata, m_rresp, m_rvalid,
        output m_rready
    );

    modport slave (
        input  m_awaddr, m_awvalid, m_awlen, m_awsize, m_awprot, m_awburst,
               m_awid, m_awcache, m_awqos, m_awregion, m_awlock,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready,
        input  m_araddr, m_arvalid, m_arlen, m_arsize, m_arprot, m_arburst,
               m_arid, m_arcache, m_arqos, m_arregion, m_arlock,
        output m_arready,
        output m_rdata, m_rresp, m_rvalid,
        input  m_rready
    );
endinterface

// File: rtl/psram_rec_play_ctrl.sv
// Record/playback sequencer: one single-beat AXI4 write per mic word, one read per playback word.
module psram_rec_play_ctrl
    import psram_rec_play_ctrl_pkg::*;
#(
    parameter int              ADDR_W    = 24,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
    parameter int              NUM_WORDS = 195312
) (
    input  logic                clk,
    input  logic                S_AXI_ARESETN,
    input  logic                rec_start,
    input  logic                play_start,
    output logic                rec_busy,
    output logic                play_busy,
    output logic                err,
    input  logic [SAMPLE_W-1:0] smp_in_data,
    input  logic                smp_in_valid,
    output logic                smp_in_ready,
    output logic [SAMPLE_W-1:0] smp_out_data,
    output logic                smp_out_valid,
    input  logic                smp_out_ready,
    psram_rec_play_ctrl_if.master m
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    ctrl_state_e         r_state, w_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_last, w_step, w_start;
    logic                r_err, r_rec_busy, r_play_busy;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_wlast;
    logic [SAMPLE_W-1:0] r_sout;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == CNT_W'(NUM_WORDS));
    assign w_start   = (r_state == S_IDLE) && (rec_start || play_start);

    always_comb begin
        w_nxt  = r_state;
        w_step = 1'b0;
        case (r_state)
            S_IDLE:      if (rec_start)          w_nxt = S_REC_WAIT;
                         else if (play_start)    w_nxt = S_PLAY_AR;
            S_REC_WAIT:  if (smp_in_valid)       w_nxt = S_REC_AW;
            S_REC_AW:    if (m.m_awready)        w_nxt = S_REC_W;
            S_REC_W:     if (m.m_wready)         w_nxt = S_REC_B;
            S_REC_B:     if (m.m_bvalid) begin
                             w_step = 1'b1;
                             w_nxt  = w_last ? S_IDLE : S_REC_WAIT;
                         end
            S_PLAY_AR:   if (m.m_arready)        w_nxt = S_PLAY_R;
            S_PLAY_R:    if (m.m_rvalid)         w_nxt = S_PLAY_HOLD;
            S_PLAY_HOLD: if (smp_out_ready) begin
                             w_step = 1'b1;
                             w_nxt  = w_last ? S_IDLE : S_PLAY_AR;
                         end
            default:                             w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!S_AXI_ARESETN) begin
            r_state     <= S_IDLE;
            r_addr      <= BASE_ADDR;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rec_busy  <= 1'b0;
            r_play_busy <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wlast     <= 1'b0;
            r_sout      <= '0;
        end else begin
            r_state     <= w_nxt;
            r_rec_busy  <= is_rec(w_nxt);
            r_play_busy <= is_play(w_nxt);
            if (w_start) begin
                r_addr <= BASE_ADDR;
                r_cnt  <= '0;
            end else if (w_step) begin
                // address wraps silently at 2^ADDR_W
                r_addr <= r_addr + ADDR_W'(4);
                r_cnt  <= w_cnt_inc;
            end
            if (r_state == S_REC_WAIT && smp_in_valid) begin
                r_wdata <= {smp_in_data, {(DATA_W-SAMPLE_W){1'b0}}};
                r_wstrb <= {2'b11, {(DATA_W/8-2){1'b0}}};
                r_wlast <= 1'b1;
            end
            if (r_state == S_REC_B && m.m_bvalid && m.m_bresp != RESP_OKAY)
                r_err <= 1'b1;
            if (r_state == S_PLAY_R && m.m_rvalid) begin
                r_sout <= m.m_rdata[DATA_W-1 -: SAMPLE_W];
                if (m.m_rresp != RESP_OKAY) r_err <= 1'b1;
            end
        end
    end

    assign rec_busy      = r_rec_busy;
    assign play_busy     = r_play_busy;
    assign err           = r_err;
    assign smp_in_ready  = (r_state == S_REC_WAIT);
    assign smp_out_valid = (r_state == S_PLAY_HOLD);
    assign smp_out_data  = r_sout;

    assign m.m_awaddr   = r_addr;
    assign m.m_awvalid  = (r_state == S_REC_AW);
    assign m.m_wdata    = r_wdata;
    assign m.m_wstrb    = r_wstrb;
    assign m.m_wlast    = r_wlast;
    assign m.m_wvalid   = (r_state == S_REC_W);
    assign m.m_bready   = (r_state == S_REC_B);
    assign m.m_araddr   = r_addr;
    assign m.m_arvalid  = (r_state == S_PLAY_AR);
    assign m.m_rready   = (r_state == S_PLAY_R);

    assign m.m_awlen    = AXI_LEN;
    assign m.m_awsize   = AXI_SIZE;
    assign m.m_awburst  = AXI_BURST;
    assign m.m_awprot   = AXI_PROT;
    assign m.m_awid     = '0;
    assign m.m_awcache  = '0;
    assign m.m_awqos    = '0;
    assign m.m_awregion = '0;
    assign m.m_awlock   = 1'b0;
    assign m.m_arlen    = AXI_LEN;
    assign m.m_arsize   = AXI_SIZE;
    assign m.m_arburst  = AXI_BURST;
    assign m.m_arprot   = AXI_PROT;
    assign m.m_arid     = '0;
    assign m.m_arcache  = '0;
    assign m.m_arqos    = '0;
    assign m.m_arregion = '0;
    assign m.m_arlock   = 1'b0;

endmodule
